// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// assembles one- and two-word instructions into the IF/ID buffer.
module fetch_stage #(
  parameter int            AW     = 16,
  parameter logic [AW-1:0] RST_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] im_addr,
  input  logic [15:0]   im_data,
  input  logic          stall,
  input  logic          flush,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          ifid_valid,
  output logic [15:0]   ifid_instr,
  output logic [15:0]   ifid_imm,
  output logic [AW-1:0] ifid_pc_next
);

  // state | meaning
  // WORD1 | fetching an opcode word
  // WORD2 | opcode parked in first_word, fetching its immediate word
  typedef enum logic {WORD1 = 1'b0, WORD2 = 1'b1} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc_inc;
  logic [15:0]   first_word;

  assign im_addr = pc;
  assign pc_inc  = pc + AW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= WORD1;
      pc           <= RST_PC;
      first_word   <= '0;
      ifid_valid   <= 1'b0;
      ifid_instr   <= '0;
      ifid_imm     <= '0;
      ifid_pc_next <= '0;
    end else if (redirect_valid) begin
      // A redirect wins over stall and drops any half-assembled instruction.
      state        <= WORD1;
      pc           <= redirect_pc;
      first_word   <= '0;
      ifid_valid   <= 1'b0;
      ifid_instr   <= '0;
      ifid_imm     <= '0;
      ifid_pc_next <= '0;
    end else if (!stall || flush) begin
      pc           <= pc_inc;
      ifid_valid   <= 1'b0;
      ifid_instr   <= '0;
      ifid_imm     <= '0;
      ifid_pc_next <= '0;
      // Flush only bubbles the buffer; the fetch itself still advances.
      case (state)
        WORD1: begin
          if (im_data[15]) begin
            first_word <= im_data;
            state      <= WORD2;
          end else if (!flush) begin
            ifid_valid   <= 1'b1;
            ifid_instr   <= im_data;
            ifid_pc_next <= pc_inc;
          end
        end
        WORD2: begin
          state <= WORD1;
          if (!flush) begin
            ifid_valid   <= 1'b1;
            ifid_instr   <= first_word;
            ifid_imm     <= im_data;
            ifid_pc_next <= pc_inc;
          end
        end
        default: state <= WORD1;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: instruction-level reference model feeds an
// expected-instruction queue that a separate monitor drains.
module tb_fetch_stage;

  typedef struct packed {
    logic        v;
    logic [15:0] instr;
    logic [15:0] imm;
    logic [15:0] pcn;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] im_addr;
  logic [15:0] im_data;
  logic        stall, flush, redirect_valid;
  logic [15:0] redirect_pc;
  logic        ifid_valid;
  logic [15:0] ifid_instr, ifid_imm, ifid_pc_next;

  logic [15:0] mem [0:65535];
  ent_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [15:0] m_pc;
  logic        m_pend;
  logic [15:0] m_first;

  always #5 clk = ~clk;
  assign im_data = mem[im_addr];

  fetch_stage #(.AW(16), .RST_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .im_addr(im_addr), .im_data(im_data),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_imm(ifid_imm), .ifid_pc_next(ifid_pc_next)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge in terms of whole instructions, called at negedge.
  task automatic step(input logic s, input logic f, input logic r, input logic [15:0] rp);
    logic [15:0] w;
    ent_t        e;
    chk("im_addr", 64'(im_addr), 64'(m_pc));
    stall = s; flush = f; redirect_valid = r; redirect_pc = rp;
    if (r) begin
      m_pc   = rp;
      m_pend = 1'b0;
    end else if (!s || f) begin
      w = mem[m_pc];
      e.v = 1'b1;
      e.pcn = m_pc + 16'd1;
      if (m_pend) begin
        e.instr = m_first;
        e.imm   = w;
        if (!f) q.push_back(e);
        m_pend = 1'b0;
      end else if (w[15]) begin
        m_pend  = 1'b1;
        m_first = w;
      end else begin
        e.instr = w;
        e.imm   = 16'h0000;
        if (!f) q.push_back(e);
      end
      m_pc = m_pc + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b0;
    #1;
    chk("rst_im_addr", 64'(im_addr), 64'h0);
    chk("rst_valid", 64'(ifid_valid), 64'h0);
    #1 rst = 1'b1;
    m_pc   = 16'h0000;
    m_pend = 1'b0;
  endtask

  // Monitor: pops an expected instruction whenever the DUT presents one.
  ent_t last, cur;
  logic mon_live, mon_held;
  initial last = '0;
  always @(posedge clk) begin
    mon_live = rst;
    mon_held = stall && !flush && !redirect_valid;
    #1;
    cur = {ifid_valid, ifid_instr, ifid_imm, ifid_pc_next};
    if (mon_live) begin
      if (mon_held) begin
        chk("stall_hold", 64'(cur), 64'(last));
      end else if (cur.v) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got %h expected none at %0t", cur, $time);
        end else begin
          chk("ifid", 64'(cur), 64'(q.pop_front()));
        end
      end else begin
        chk("bubble_fields", 64'(cur), 64'h0);
        chk("missing_instr", 64'(q.size()), 64'h0);
      end
    end
    last = cur;
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h8005; mem[5] = 16'hBEEF; mem[6] = 16'h0666; mem[7] = 16'h0777;
    mem[8] = 16'h0888; mem[9] = 16'h8005; mem[10] = 16'h1234;
    mem[16'h0040] = 16'h0042; mem[16'hFFFF] = 16'h8777;
    mem[16'h0020] = 16'h8ABC;

    rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    m_pc = 16'h0000; m_pend = 1'b0; m_first = '0;
    #1;
    chk("reset_im_addr", 64'(im_addr), 64'h0);
    chk("reset_ifid", 64'({ifid_valid, ifid_instr, ifid_imm, ifid_pc_next}), 64'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, '0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    step(0, 1, 0, '0);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    step(1, 0, 1, 16'h0040);
    step(0, 0, 0, '0);
    step(0, 0, 1, 16'hFFFF);
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    step(0, 0, 1, 16'h0020);
    step(0, 0, 0, '0);
    reset_pulse();
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 19) == 0), 16'($urandom));
    end
    step(0, 0, 0, '0);
    step(0, 0, 0, '0);
    chk("drain", 64'(q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
